// File: rtl/dmem_scheduler.sv
// Single-port data-memory scheduler: in-order store buffer with drain,
// store-to-load forwarding, and starvation-bounded arbitration between loads and drains.
module dmem_scheduler #(
   parameter int unsigned SB_DEPTH     = 4,
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned TAG_W        = 6
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_st_valid,
   output logic                      o_st_ready,
   input  logic [31:0]               i_st_addr,
   input  logic [31:0]               i_st_data,
   input  logic                      i_ld_valid,
   output logic                      o_ld_ready,
   input  logic [31:0]               i_ld_addr,
   input  logic [TAG_W-1:0]          i_ld_tag,
   output logic                      o_ld_resp_valid,
   output logic [TAG_W-1:0]          o_ld_resp_tag,
   output logic [31:0]               o_ld_resp_data,
   output logic                      o_ld_resp_fwd,
   output logic [$clog2(SB_DEPTH):0] o_sb_count,
   output logic                      o_sb_empty,
   output logic                      o_mem_read,
   output logic                      o_mem_write,
   output logic [31:0]               o_mem_addr,
   output logic [31:0]               o_mem_wdata,
   input  logic [31:0]               i_mem_rdata
);

   localparam int unsigned PTR_W = $clog2(SB_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } sb_entry_t;

   sb_entry_t        r_sb [SB_DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic [STV_W-1:0] r_starve;
   logic             r_resp_valid;
   logic [TAG_W-1:0] r_resp_tag;
   logic [31:0]      r_resp_data;
   logic             r_resp_fwd;

   logic             w_drain_req;
   logic             w_full;
   logic             w_force_drain;
   logic             w_fwd_match;
   logic [31:0]      w_fwd_data;
   logic             w_fwd_hit;
   logic             w_enq;
   logic             w_drain;
   logic             w_mem_ld;
   logic             w_ld_acc;

   assign w_drain_req   = (r_count != '0);
   assign w_full        = (r_count == CNT_W'(SB_DEPTH));
   assign w_force_drain = w_drain_req && (w_full || (r_starve == STV_W'(STARVE_LIMIT)));
   assign o_st_ready    = !i_reset && !w_full;
   assign w_enq         = i_st_valid && o_st_ready;
   assign w_fwd_hit     = i_ld_valid && w_fwd_match;

   // Scan oldest to youngest over occupied slots so the youngest match wins.
   always_comb begin
      w_fwd_match = 1'b0;
      w_fwd_data  = '0;
      for (int unsigned k = 0; k < SB_DEPTH; k++) begin
         if ((CNT_W'(k) < r_count) &&
             (r_sb[r_head + PTR_W'(k)].addr[31:2] == i_ld_addr[31:2])) begin
            w_fwd_match = 1'b1;
            w_fwd_data  = r_sb[r_head + PTR_W'(k)].data;
         end
      end
   end

   // Port arbitration: forwarded loads bypass the port, forced drains beat memory loads.
   always_comb begin
      w_drain  = 1'b0;
      w_mem_ld = 1'b0;
      w_ld_acc = 1'b0;
      if (!i_reset) begin
         if (w_fwd_hit) begin
            w_ld_acc = 1'b1;
            w_drain  = w_drain_req;
         end else if (i_ld_valid && !w_force_drain) begin
            w_ld_acc = 1'b1;
            w_mem_ld = 1'b1;
         end else if (w_drain_req) begin
            w_drain  = 1'b1;
         end
      end
   end

   always_comb begin
      o_ld_ready  = w_ld_acc;
      o_mem_read  = w_mem_ld;
      o_mem_write = w_drain;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (w_mem_ld) begin
         o_mem_addr = i_ld_addr;
      end else if (w_drain) begin
         o_mem_addr  = r_sb[r_head].addr;
         o_mem_wdata = r_sb[r_head].data;
      end
   end

   // Entry storage carries no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge i_clk) begin
      if (w_enq) begin
         r_sb[r_tail] <= '{addr: i_st_addr, data: i_st_data};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_starve <= '0;
      end else begin
         if (w_enq) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_drain) begin
            r_head <= r_head + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_drain);
         if (w_drain || !w_drain_req) begin
            r_starve <= '0;
         end else if (w_mem_ld && (r_starve != STV_W'(STARVE_LIMIT))) begin
            r_starve <= r_starve + STV_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_resp_valid <= 1'b0;
         r_resp_tag   <= '0;
         r_resp_data  <= '0;
         r_resp_fwd   <= 1'b0;
      end else if (w_ld_acc) begin
         r_resp_valid <= 1'b1;
         r_resp_tag   <= i_ld_tag;
         r_resp_data  <= w_fwd_hit ? w_fwd_data : i_mem_rdata;
         r_resp_fwd   <= w_fwd_hit;
      end else begin
         r_resp_valid <= 1'b0;
      end
   end

   assign o_ld_resp_valid = r_resp_valid;
   assign o_ld_resp_tag   = r_resp_tag;
   assign o_ld_resp_data  = r_resp_data;
   assign o_ld_resp_fwd   = r_resp_fwd;
   assign o_sb_count      = r_count;
   assign o_sb_empty      = (r_count == '0);

endmodule

// File: tb/tb_dmem_scheduler.sv
// Self-checking bench for dmem_scheduler: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_dmem_scheduler;

   localparam int unsigned SB_DEPTH     = 4;
   localparam int unsigned STARVE_LIMIT = 8;
   localparam int unsigned TAG_W        = 6;

   logic              clk = 1'b0;
   logic              reset;
   logic              st_valid, st_ready;
   logic [31:0]       st_addr, st_data;
   logic              ld_valid, ld_ready;
   logic [31:0]       ld_addr;
   logic [TAG_W-1:0]  ld_tag;
   logic              ld_resp_valid;
   logic [TAG_W-1:0]  ld_resp_tag;
   logic [31:0]       ld_resp_data;
   logic              ld_resp_fwd;
   logic [2:0]        sb_count;
   logic              sb_empty;
   logic              mem_read, mem_write;
   logic [31:0]       mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   dmem_scheduler #(.SB_DEPTH(SB_DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .TAG_W(TAG_W)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_st_valid(st_valid), .o_st_ready(st_ready), .i_st_addr(st_addr), .i_st_data(st_data),
      .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_addr(ld_addr), .i_ld_tag(ld_tag),
      .o_ld_resp_valid(ld_resp_valid), .o_ld_resp_tag(ld_resp_tag),
      .o_ld_resp_data(ld_resp_data), .o_ld_resp_fwd(ld_resp_fwd),
      .o_sb_count(sb_count), .o_sb_empty(sb_empty),
      .o_mem_read(mem_read), .o_mem_write(mem_write),
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );

   // Environment memory: unwritten words read back a recognisable pattern.
   bit [31:0] env_d [256];
   bit        env_v [256];
   always @(posedge clk) begin
      if (mem_write) begin
         env_d[mem_addr[9:2]] <= mem_wdata;
         env_v[mem_addr[9:2]] <= 1'b1;
      end
   end
   assign mem_rdata = env_v[mem_addr[9:2]] ? env_d[mem_addr[9:2]]
                                           : (32'hA000_0000 | {24'b0, mem_addr[9:2]});

   function automatic logic [31:0] pat(input logic [7:0] w);
      return 32'hA000_0000 | {24'b0, w};
   endfunction

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model state
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } ent_t;
   ent_t        q[$];
   int          starve;
   bit          m_rv;
   logic [5:0]  m_rt;
   logic [31:0] m_rd;
   bit          m_rf;
   bit [31:0]   ref_d [256];
   bit          ref_v [256];
   bit          chk_en;

   logic        obs_mw, obs_mr, obs_lr, obs_sr, obs_rv, obs_rf;
   logic [31:0] obs_ma, obs_wd, obs_rd;
   logic [2:0]  obs_cnt;

   // One clock cycle: drive, compare against the model before the edge, advance the model.
   task automatic cyc(input bit rst, input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                      input bit lv, input logic [31:0] la, input logic [5:0] lt);
      int          hit;
      bit          full, force_d, acc, mrd, drn;
      logic [31:0] ea, ew;
      reset = rst; st_valid = sv; st_addr = sa; st_data = sd;
      ld_valid = lv; ld_addr = la; ld_tag = lt;
      #1;
      full = (q.size() == SB_DEPTH);
      hit = -1;
      if (lv) for (int i = 0; i < q.size(); i++) if (q[i].addr[31:2] == la[31:2]) hit = i;
      force_d = (q.size() > 0) && (full || starve == STARVE_LIMIT);
      acc = 0; mrd = 0; drn = 0;
      if (!rst) begin
         if (hit >= 0) begin acc = 1; drn = (q.size() > 0); end
         else if (lv && !force_d) begin acc = 1; mrd = 1; end
         else if (q.size() > 0) drn = 1;
      end
      ea = mrd ? la : (drn ? q[0].addr : 32'h0);
      ew = drn ? q[0].data : 32'h0;
      obs_mw = mem_write; obs_mr = mem_read; obs_lr = ld_ready; obs_sr = st_ready;
      obs_ma = mem_addr; obs_wd = mem_wdata; obs_rv = ld_resp_valid;
      obs_rd = ld_resp_data; obs_rf = ld_resp_fwd; obs_cnt = sb_count;
      if (chk_en) begin
         chk("ld_ready", ld_ready, acc);
         chk("st_ready", st_ready, !rst && !full);
         chk("mem_read", mem_read, mrd);
         chk("mem_write", mem_write, drn);
         chk("mem_addr", mem_addr, ea);
         chk("mem_wdata", mem_wdata, ew);
         chk("sb_count", 32'(sb_count), 32'(q.size()));
         chk("sb_empty", sb_empty, q.size() == 0);
         chk("resp_valid", ld_resp_valid, m_rv);
         chk("resp_tag", 32'(ld_resp_tag), 32'(m_rt));
         chk("resp_data", ld_resp_data, m_rd);
         chk("resp_fwd", ld_resp_fwd, m_rf);
      end
      @(posedge clk);
      if (rst) begin
         q.delete(); starve = 0; m_rv = 0; m_rt = '0; m_rd = '0; m_rf = 0;
      end else begin
         if (acc) begin
            m_rv = 1; m_rt = lt; m_rf = (hit >= 0);
            if (hit >= 0) m_rd = q[hit].data;
            else m_rd = ref_v[la[9:2]] ? ref_d[la[9:2]] : pat(la[9:2]);
         end else m_rv = 0;
         if (drn || q.size() == 0) starve = 0;
         else if (mrd && starve < STARVE_LIMIT) starve++;
         if (drn) begin
            ref_d[q[0].addr[9:2]] = q[0].data;
            ref_v[q[0].addr[9:2]] = 1;
            void'(q.pop_front());
         end
         if (sv && !full) q.push_back('{sa, sd});
      end
      @(negedge clk);
   endtask

   typedef struct {
      bit          sv;
      logic [31:0] sa, sd;
      bit          lv;
      logic [31:0] la;
      logic [5:0]  lt;
      bit          e_mw, e_mr;
      logic [31:0] e_ma, e_wd;
      bit          e_lr, e_rv;
      logic [31:0] e_rd;
      bit          e_rf;
   } vec_t;

   vec_t tbl [17];

   initial begin
      int drain_at, lr_at, lr_after, blk_at, mw_blk, sr_after, s, n;
      logic [31:0] la;

      reset = 1; st_valid = 0; st_addr = 0; st_data = 0;
      ld_valid = 0; ld_addr = 0; ld_tag = 0;
      starve = 0; m_rv = 0; m_rt = 0; m_rd = 0; m_rf = 0; chk_en = 0;

      //              sv st_addr  st_data       lv ld_addr  tg mw mr mem_addr wdata      lr rv resp_data     rf
      tbl[0]  = '{1, 32'h40, 32'hDEADBEEF, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0};
      tbl[1]  = '{0, 32'h0,  32'h0,        0, 32'h0,   0, 1, 0, 32'h40, 32'hDEADBEEF, 0, 0, 32'h0,        0};
      tbl[2]  = '{0, 32'h0,  32'h0,        0, 32'h0,   0, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0};
      tbl[3]  = '{0, 32'h0,  32'h0,        1, 32'h40,  1, 0, 1, 32'h40, 32'h0,        1, 0, 32'h0,        0};
      tbl[4]  = '{0, 32'h0,  32'h0,        0, 32'h0,   0, 0, 0, 32'h0,  32'h0,        0, 1, 32'hDEADBEEF, 0};
      tbl[5]  = '{1, 32'h80, 32'h11,       1, 32'h100, 2, 0, 1, 32'h100,32'h0,        1, 0, 32'h0,        0};
      tbl[6]  = '{1, 32'h80, 32'h22,       1, 32'h100, 3, 0, 1, 32'h100,32'h0,        1, 1, 32'hA0000040, 0};
      tbl[7]  = '{1, 32'h84, 32'h33,       1, 32'h100, 4, 0, 1, 32'h100,32'h0,        1, 1, 32'hA0000040, 0};
      tbl[8]  = '{0, 32'h0,  32'h0,        1, 32'h100, 5, 0, 1, 32'h100,32'h0,        1, 1, 32'hA0000040, 0};
      tbl[9]  = '{0, 32'h0,  32'h0,        1, 32'h82,  6, 1, 0, 32'h80, 32'h11,       1, 1, 32'hA0000040, 0};
      tbl[10] = '{0, 32'h0,  32'h0,        0, 32'h0,   0, 1, 0, 32'h80, 32'h22,       0, 1, 32'h22,       1};
      tbl[11] = '{0, 32'h0,  32'h0,        0, 32'h0,   0, 1, 0, 32'h84, 32'h33,       0, 0, 32'h0,        0};
      tbl[12] = '{0, 32'h0,  32'h0,        1, 32'h80,  7, 0, 1, 32'h80, 32'h0,        1, 0, 32'h0,        0};
      tbl[13] = '{0, 32'h0,  32'h0,        0, 32'h0,   0, 0, 0, 32'h0,  32'h0,        0, 1, 32'h22,       0};
      tbl[14] = '{1, 32'hC0, 32'h55,       1, 32'hC0,  8, 0, 1, 32'hC0, 32'h0,        1, 0, 32'h0,        0};
      tbl[15] = '{0, 32'h0,  32'h0,        0, 32'h0,   0, 1, 0, 32'hC0, 32'h55,       0, 1, 32'hA0000030, 0};
      tbl[16] = '{0, 32'h0,  32'h0,        0, 32'h0,   0, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0};

      @(negedge clk);
      // Reset with both request valids held high
      cyc(1, 1, 32'h10, 32'h1, 1, 32'h10, 6'h3);
      chk_en = 1;
      cyc(1, 1, 32'h10, 32'h1, 1, 32'h10, 6'h3);
      chk("rst_ld_ready", obs_lr, 0);
      chk("rst_st_ready", obs_sr, 0);
      chk("rst_sb_empty", sb_empty, 1);
      chk("rst_resp_valid", ld_resp_valid, 0);

      // Directed vectors: basic drain, forwarding, same-cycle store+load
      for (int r = 0; r < 17; r++) begin
         cyc(0, tbl[r].sv, tbl[r].sa, tbl[r].sd, tbl[r].lv, tbl[r].la, tbl[r].lt);
         chk($sformatf("row%0d_mw", r), obs_mw, tbl[r].e_mw);
         chk($sformatf("row%0d_mr", r), obs_mr, tbl[r].e_mr);
         chk($sformatf("row%0d_ma", r), obs_ma, tbl[r].e_ma);
         if (tbl[r].e_mw) chk($sformatf("row%0d_wd", r), obs_wd, tbl[r].e_wd);
         chk($sformatf("row%0d_lr", r), obs_lr, tbl[r].e_lr);
         chk($sformatf("row%0d_rv", r), obs_rv, tbl[r].e_rv);
         if (tbl[r].e_rv) begin
            chk($sformatf("row%0d_rd", r), obs_rd, tbl[r].e_rd);
            chk($sformatf("row%0d_rf", r), obs_rf, tbl[r].e_rf);
         end
      end

      // Starvation: one buffered store against a stream of non-matching loads
      cyc(0, 1, 32'h200, 32'hCAFE, 0, 32'h0, 0);
      drain_at = 0; lr_at = 1; lr_after = 0;
      for (int i = 1; i <= 20; i++) begin
         cyc(0, 0, 32'h0, 32'h0, 1, 32'h300, 6'(i));
         if (obs_mw && drain_at == 0) begin drain_at = i; lr_at = obs_lr; end
         if (i == 10) lr_after = obs_lr;
      end
      chk("starve_drain_cycle", 32'(drain_at), 32'd9);
      chk("starve_ld_ready", 32'(lr_at), 32'd0);
      chk("starve_resume", 32'(lr_after), 32'd1);

      // Full buffer while loads hog the port
      s = 0; blk_at = -1; mw_blk = 0; sr_after = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(0, s < 5, 32'h400 + 32'(4 * s), 32'hF0 + 32'(s), 1, 32'h300, 6'(i));
         if (blk_at >= 0 && i == blk_at + 1) sr_after = obs_sr;
         if (!obs_sr && blk_at < 0) begin blk_at = i; mw_blk = obs_mw; chk("full_count", 32'(obs_cnt), 32'd4); end
         if (obs_sr && s < 5) s++;
      end
      chk("full_block_cycle", 32'(blk_at), 32'd4);
      chk("full_force_drain", 32'(mw_blk), 32'd1);
      chk("full_ready_again", 32'(sr_after), 32'd1);
      n = 0;
      while (!sb_empty && n < 40) begin cyc(0, 0, 0, 0, 0, 0, 0); n++; end
      chk("full_drained", sb_empty, 1);
      for (int i = 0; i < 5; i++) chk($sformatf("full_mem%0d", i), env_d[8'h00 + 8'(i)], 32'hF0 + 32'(i));

      // Wrap: ten stores pass through the circular buffer
      s = 0; n = 0;
      while (s < 10 && n < 60) begin
         cyc(0, 1, 32'h280 + 32'(4 * s), 32'h1111 * 32'(s + 1), 0, 0, 0);
         if (obs_sr) s++;
         n++;
      end
      chk("wrap_all_enqueued", 32'(s), 32'd10);
      n = 0;
      while (!sb_empty && n < 40) begin cyc(0, 0, 0, 0, 0, 0, 0); n++; end
      chk("wrap_drained", sb_empty, 1);
      for (int i = 0; i < 10; i++) chk($sformatf("wrap_mem%0d", i), env_d[8'hA0 + 8'(i)], 32'h1111 * 32'(i + 1));

      // Randomized traffic over a small address window, with occasional reset
      for (int i = 0; i < 3000; i++) begin
         la = {22'b0, 8'h40 + 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         cyc($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
             {22'b0, 8'h40 + 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3))}, $urandom,
             $urandom_range(0, 9) < 6, la, 6'($urandom_range(0, 63)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
